// File: rtl/layer_pkg.sv
// Shared constants and controller state encoding for the layer datapath.
// Imported by layer_ctrl and any block that decodes its state.
package layer_pkg;

   localparam int DEF_ROWS    = 30;
   localparam int DEF_COLUMNS = 64;
   localparam int DATAWIDTH   = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      RUN    = 3'd2,
      RESULT = 3'd3,
      TRAIN  = 3'd4,
      ERROR  = 3'd5
   } layer_ctrl_state_t;

endpackage

// File: rtl/layer_ctrl.sv
// Sequencer for one layer: clear/run/result for inference, weight-row burst for training.
// Optional RUN watchdog enabled by defining LAYER_CTRL_TIMEOUT_EN.
module layer_ctrl
   import layer_pkg::*;
#(
   parameter int ROWS    = DEF_ROWS,
   parameter int COLUMNS = DEF_COLUMNS,
   parameter int TIMEOUT = COLUMNS + 32
) (
   input  logic                    clk,
   input  logic                    rst_overall,
   input  logic                    start,
   input  logic                    mode,
   input  logic                    wt_valid,
   output logic                    wt_ready,
   input  logic                    wt_last,
   output logic                    lyr_rst_vals,
   output logic                    lyr_en,
   output logic                    lyr_train_en,
   output logic [$clog2(ROWS)-1:0] lyr_row_sel,
   input  logic                    lyr_done,
   output logic                    busy,
   output logic                    res_valid,
   output logic                    err
);

   localparam int RW = $clog2(ROWS);
   localparam logic [RW-1:0] PARK = RW'(ROWS);
   localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

   // The park code must be a real encoding that addresses no row.
   if ((ROWS & (ROWS - 1)) == 0) begin : g_rows_pow2
      $error("layer_ctrl: ROWS must not be a power of two");
   end
   if (TIMEOUT < 1 || COLUMNS < 1) begin : g_bad_cfg
      $error("layer_ctrl: TIMEOUT and COLUMNS must be positive");
   end

   layer_ctrl_state_t state_q;
   logic [RW-1:0]     cnt_q;
   logic              armed_q;
   logic              rst_vals_q;
   logic              en_q;
   logic              train_q;
   logic              res_q;
   logic              err_q;
`ifdef LAYER_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]     cyc_q;
`endif

   // Main FSM with registered layer controls; armed_q masks start at reset release.
   always_ff @(posedge clk or posedge rst_overall) begin
      if (rst_overall) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         armed_q    <= 1'b0;
         rst_vals_q <= 1'b0;
         en_q       <= 1'b0;
         train_q    <= 1'b0;
         res_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef LAYER_CTRL_TIMEOUT_EN
         cyc_q      <= '0;
`endif
      end else begin
         armed_q    <= 1'b1;
         rst_vals_q <= 1'b0;
         res_q      <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && armed_q) begin
                  if (mode) begin
                     state_q <= TRAIN;
                     train_q <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q    <= CLEAR;
                     rst_vals_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               state_q <= RUN;
               en_q    <= 1'b1;
`ifdef LAYER_CTRL_TIMEOUT_EN
               cyc_q   <= '0;
`endif
            end
            RUN: begin
               if (lyr_done) begin
                  state_q <= RESULT;
                  en_q    <= 1'b0;
                  res_q   <= 1'b1;
               end
`ifdef LAYER_CTRL_TIMEOUT_EN
               else if (cyc_q == CW'(TIMEOUT - 1)) begin
                  state_q <= ERROR;
                  en_q    <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cyc_q <= cyc_q + 1'b1;
               end
`endif
            end
            RESULT: begin
               state_q <= IDLE;
            end
            TRAIN: begin
               if (wt_valid) begin
                  if (wt_last) begin
                     train_q <= 1'b0;
                     cnt_q   <= '0;
                     if (cnt_q == LAST) begin
                        state_q <= IDLE;
                     end else begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                     end
                  end else if (cnt_q == LAST) begin
                     train_q <= 1'b0;
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ERROR: begin
               state_q <= ERROR;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Row select follows accepted beats; stalls and other states park on a non-row.
   always_comb begin
      wt_ready    = (state_q == TRAIN);
      lyr_row_sel = PARK;
      if (state_q == TRAIN && wt_valid) begin
         lyr_row_sel = cnt_q;
      end
   end

   assign busy         = (state_q != IDLE);
   assign lyr_rst_vals = rst_vals_q;
   assign lyr_en       = en_q;
   assign lyr_train_en = train_q;
   assign res_valid    = res_q;
   assign err          = err_q;

endmodule

// File: tb/tb_layer_ctrl.sv
// Directed bench for layer_ctrl with default ROWS=30, COLUMNS=64.
// Define LAYER_CTRL_TIMEOUT_EN for both RTL and bench to cover the watchdog.
module tb_layer_ctrl;

   logic       clk = 1'b0;
   logic       rst_overall = 1'b1;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       wt_valid = 1'b0;
   logic       wt_ready;
   logic       wt_last = 1'b0;
   logic       lyr_rst_vals;
   logic       lyr_en;
   logic       lyr_train_en;
   logic [4:0] lyr_row_sel;
   logic       lyr_done = 1'b0;
   logic       busy;
   logic       res_valid;
   logic       err;

   int n_chk = 0;
   int n_fail = 0;

   layer_ctrl dut (
      .clk          (clk),
      .rst_overall  (rst_overall),
      .start        (start),
      .mode         (mode),
      .wt_valid     (wt_valid),
      .wt_ready     (wt_ready),
      .wt_last      (wt_last),
      .lyr_rst_vals (lyr_rst_vals),
      .lyr_en       (lyr_en),
      .lyr_train_en (lyr_train_en),
      .lyr_row_sel  (lyr_row_sel),
      .lyr_done     (lyr_done),
      .busy         (busy),
      .res_valid    (res_valid),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_overall = 1'b1;
      @(negedge clk);
      rst_overall = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [5:0] got;
      #2;
      got = {lyr_rst_vals, lyr_en, lyr_train_en, busy, res_valid, err};
      n_chk++;
      if (got !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outs got=%b want=000000", got);
      end
      n_chk++;
      if (lyr_row_sel !== 5'd30 || wt_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sel got=%0d/%b want=30/0", lyr_row_sel, wt_ready);
      end
      // start held across reset release must be ignored
      start = 1'b1;
      mode  = 1'b0;
      @(negedge clk);
      rst_overall = 1'b0;
      tick();
      start = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || lyr_rst_vals !== 1'b0) begin
         n_fail++;
         $display("FAIL start_at_release got busy=%b rv=%b want 0/0", busy, lyr_rst_vals);
      end
      tick();
   endtask

   task automatic test_inference();
      int en_cnt = 0;
      int bad = 0;
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      n_chk++;
      if (lyr_rst_vals !== 1'b1 || lyr_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clear got rv=%b en=%b busy=%b want 1/0/1", lyr_rst_vals, lyr_en, busy);
      end
      tick();
      for (int n = 1; n <= 75; n++) begin
         if (lyr_en === 1'b1) en_cnt++;
         if (lyr_rst_vals !== 1'b0 || lyr_train_en !== 1'b0 || res_valid !== 1'b0) bad++;
         // start during RUN must not disturb anything
         start = (n == 10);
         lyr_done = (n == 75);
         tick();
      end
      start = 1'b0;
      lyr_done = 1'b0;
      n_chk++;
      if (en_cnt !== 75 || bad !== 0) begin
         n_fail++;
         $display("FAIL run_en got cnt=%0d bad=%0d want 75/0", en_cnt, bad);
      end
      n_chk++;
      if (res_valid !== 1'b1 || lyr_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL result got rv=%b en=%b busy=%b want 1/0/1", res_valid, lyr_en, busy);
      end
      tick();
      n_chk++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL post_result got rv=%b busy=%b err=%b want 0/0/0", res_valid, busy, err);
      end
   endtask

   // Drive a burst of nbeats beats; stall 3 cycles after row stall_after (<0 none).
   task automatic run_train(input int nbeats, input int last_at,
                            input int stall_after, output int sel_bad,
                            output int rises, output int stall_bad);
      logic prev;
      sel_bad = 0;
      rises = 0;
      stall_bad = 0;
      prev = lyr_train_en;
      start = 1'b1;
      mode  = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         if (lyr_train_en && !prev) rises++;
         prev = lyr_train_en;
         wt_valid = 1'b1;
         wt_last  = (i == last_at);
         #1;
         if (lyr_row_sel !== 5'(i) || wt_ready !== 1'b1) sel_bad++;
         tick();
         if (i == stall_after) begin
            wt_valid = 1'b0;
            wt_last  = 1'b0;
            for (int s = 0; s < 3; s++) begin
               if (lyr_train_en && !prev) rises++;
               prev = lyr_train_en;
               #1;
               if (lyr_row_sel !== 5'd30 || lyr_train_en !== 1'b1) stall_bad++;
               tick();
            end
         end
      end
      wt_valid = 1'b0;
      wt_last  = 1'b0;
      if (lyr_train_en && !prev) rises++;
   endtask

   task automatic test_train_nostall();
      int sb, r, st;
      run_train(30, 29, -1, sb, r, st);
      n_chk++;
      if (sb !== 0) begin
         n_fail++;
         $display("FAIL train_rows got bad=%0d want 0", sb);
      end
      n_chk++;
      if (r !== 1) begin
         n_fail++;
         $display("FAIL train_edges got=%0d want 1", r);
      end
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b0 || lyr_train_en !== 1'b0) begin
         n_fail++;
         $display("FAIL train_end got err=%b busy=%b ten=%b want 0/0/0", err, busy, lyr_train_en);
      end
      tick();
   endtask

   task automatic test_train_stall();
      int sb, r, st;
      run_train(30, 29, 4, sb, r, st);
      n_chk++;
      if (st !== 0) begin
         n_fail++;
         $display("FAIL stall_park got bad=%0d want 0", st);
      end
      n_chk++;
      if (sb !== 0 || r !== 1) begin
         n_fail++;
         $display("FAIL stall_resume got bad=%0d edges=%0d want 0/1", sb, r);
      end
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_end got err=%b busy=%b want 0/0", err, busy);
      end
      tick();
   endtask

   task automatic check_error(input string tag);
      logic [5:0] got;
      got = {err, busy, lyr_rst_vals, lyr_en, lyr_train_en, wt_ready};
      n_chk++;
      if (got !== 6'b110000 || lyr_row_sel !== 5'd30) begin
         n_fail++;
         $display("FAIL %s got=%b sel=%0d want=110000 sel=30", tag, got, lyr_row_sel);
      end
   endtask

   task automatic test_short_burst();
      int sb, r, st;
      run_train(10, 9, -1, sb, r, st);
      check_error("short_burst");
      // ERROR holds and ignores start
      start = 1'b1;
      mode  = 1'b0;
      tick();
      tick();
      start = 1'b0;
      check_error("error_hold");
      do_reset();
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear got err=%b busy=%b want 0/0", err, busy);
      end
   endtask

   task automatic test_overrun();
      int sb, r, st;
      run_train(30, -1, -1, sb, r, st);
      check_error("overrun");
      do_reset();
   endtask

   task automatic test_timeout();
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      tick();
`ifdef LAYER_CTRL_TIMEOUT_EN
      for (int n = 1; n < 96; n++) tick();
      n_chk++;
      if (lyr_en !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_c96 got en=%b err=%b want 1/0", lyr_en, err);
      end
      tick();
      check_error("timeout");
`else
      for (int n = 1; n < 200; n++) tick();
      n_chk++;
      if (lyr_en !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL no_tmo got en=%b err=%b busy=%b want 1/0/1", lyr_en, err, busy);
      end
`endif
      do_reset();
   endtask

   task automatic test_reset_mid_run();
      int rv = 0;
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      tick();
      for (int n = 1; n < 20; n++) tick();
      #2;
      rst_overall = 1'b1;
      #1;
      n_chk++;
      if (lyr_en !== 1'b0 || busy !== 1'b0 || lyr_row_sel !== 5'd30 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_run_rst got en=%b busy=%b sel=%0d err=%b want 0/0/30/0",
                  lyr_en, busy, lyr_row_sel, err);
      end
      @(negedge clk);
      rst_overall = 1'b0;
      lyr_done = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (res_valid !== 1'b0) rv++;
      end
      lyr_done = 1'b0;
      n_chk++;
      if (rv !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_res_after_rst got rv=%0d busy=%b want 0/0", rv, busy);
      end
   endtask

   task automatic test_idle_sel();
      wt_valid = 1'b1;
      #1;
      n_chk++;
      if (lyr_row_sel !== 5'd30 || wt_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_sel got sel=%0d rdy=%b want 30/0", lyr_row_sel, wt_ready);
      end
      wt_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_idle_sel();
      test_inference();
      test_train_nostall();
      test_train_stall();
      test_inference();
      test_short_burst();
      test_overrun();
      test_timeout();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
